// File: rtl/alu_pkg.sv
// Shared definitions for alu_core: op codes, status flag bit positions, FSM state encoding.
// Latency: n/a (definitions only).
// Backpressure: n/a.
// Status byte layout: C=7, Z=6, I=5, D=4, B=3, bit 2 unused, V=1, N=0.
// I, B and bit 2 are only ever copied through, so they get no named index here.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_ADC  = 4'd1;
  localparam logic [3:0] OP_SBC  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_EOR  = 4'd4;
  localparam logic [3:0] OP_ORA  = 4'd5;
  localparam logic [3:0] OP_BIT  = 4'd6;
  localparam logic [3:0] OP_ASL  = 4'd7;
  localparam logic [3:0] OP_LSR  = 4'd8;
  localparam logic [3:0] OP_ROL  = 4'd9;
  localparam logic [3:0] OP_ROR  = 4'd10;
  localparam logic [3:0] OP_PASS = 4'd11;

  localparam int FLAG_C = 7;
  localparam int FLAG_Z = 6;
  localparam int FLAG_D = 4;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_BCD  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Ops that take the nibble-serial decimal path when D is set.
  function automatic logic is_arith(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_ADC) || (op == OP_SBC);
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decimal digit add/subtract with carry in/out (purely combinational).
// Latency: 0 cycles.
// Backpressure: none.
// Ports: sub_i selects subtract; a_i/b_i nibble operands; c_i carry in
//        (1 = no borrow when subtracting); digit_o result nibble; c_o carry out.
// Nibbles above 9 are not range-checked; the adjust rule applies as-is.
module bcd_digit (
  input  logic       sub_i,
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] digit_o,
  output logic       c_o
);

  logic [4:0] sum;
  logic [4:0] diff;  // two's complement, range -16..15

  always_comb begin
    sum  = {1'b0, a_i} + {1'b0, b_i} + {4'b0, c_i};
    diff = {1'b0, a_i} - {1'b0, b_i} - {4'b0, ~c_i};
    if (sub_i) begin
      if (diff[4]) begin
        digit_o = diff[3:0] - 4'd6;
        c_o     = 1'b0;
      end else begin
        digit_o = diff[3:0];
        c_o     = 1'b1;
      end
    end else if (sum > 5'd9) begin
      digit_o = sum[3:0] + 4'd6;
      c_o     = 1'b1;
    end else begin
      digit_o = sum[3:0];
      c_o     = 1'b0;
    end
  end

endmodule

// File: rtl/alu_core.sv
// 6502-style ALU: binary ops in one EXEC cycle, decimal ADD/ADC/SBC one nibble per cycle.
// Latency: 1 cycle binary, WIDTH/4 cycles decimal, from accept to out_valid.
// Backpressure: single operation in flight; in_ready low until DONE is drained by out_ready.
// Ports: clk/rst (sync, active-high); in_valid/in_ready with op, a, b, status_in;
//        out_valid/out_ready with result, status_out.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [7:0]       status_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [7:0]       status_out
);

  localparam int NDIG = WIDTH / 4;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [WIDTH-1:0] NIB_MASK = {{(WIDTH-4){1'b0}}, 4'hF};

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [7:0]       stin_q, stin_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [7:0]       status_q, status_d;

  // Binary adder, shared by EXEC and by the decimal-mode V flag.
  logic [WIDTH-1:0] b_eff;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic             bin_v;

  always_comb begin
    b_eff = (op_q == OP_SBC) ? ~b_q : b_q;
    cin   = (op_q == OP_ADD) ? 1'b0 : stin_q[FLAG_C];
    sum   = {1'b0, a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
    bin_v = (a_q[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
  end

  // Single-cycle result for every non-decimal op.
  logic [WIDTH-1:0] exec_res;
  logic [7:0]       exec_st;
  logic             upd_zn;

  always_comb begin
    exec_res = a_q;
    exec_st  = stin_q;
    upd_zn   = 1'b1;
    case (op_q)
      OP_ADD, OP_ADC, OP_SBC: begin
        exec_res        = sum[WIDTH-1:0];
        exec_st[FLAG_C] = sum[WIDTH];
        exec_st[FLAG_V] = bin_v;
      end
      OP_AND:  exec_res = a_q & b_q;
      OP_EOR:  exec_res = a_q ^ b_q;
      OP_ORA:  exec_res = a_q | b_q;
      OP_BIT: begin
        exec_res        = a_q;
        exec_st[FLAG_Z] = ~|(a_q & b_q);
        exec_st[FLAG_N] = b_q[WIDTH-1];
        exec_st[FLAG_V] = b_q[WIDTH-2];
        upd_zn          = 1'b0;
      end
      OP_ASL: begin
        exec_res        = {b_q[WIDTH-2:0], 1'b0};
        exec_st[FLAG_C] = b_q[WIDTH-1];
      end
      OP_LSR: begin
        exec_res        = {1'b0, b_q[WIDTH-1:1]};
        exec_st[FLAG_C] = b_q[0];
      end
      OP_ROL: begin
        exec_res        = {b_q[WIDTH-2:0], stin_q[FLAG_C]};
        exec_st[FLAG_C] = b_q[WIDTH-1];
      end
      OP_ROR: begin
        exec_res        = {stin_q[FLAG_C], b_q[WIDTH-1:1]};
        exec_st[FLAG_C] = b_q[0];
      end
      OP_PASS: exec_res = b_q;
      default: upd_zn   = 1'b0;  // reserved: status passes through untouched
    endcase
    if (upd_zn) begin
      exec_st[FLAG_Z] = ~|exec_res;
      exec_st[FLAG_N] = exec_res[WIDTH-1];
    end
  end

  // Decimal path: one shared digit cell, nibble selected by the counter.
  logic [CW+1:0]    nib_sh;
  logic [3:0]       a_nib, b_nib, dig;
  logic             dig_c;
  logic [WIDTH-1:0] bcd_res;
  logic [7:0]       bcd_st;

  assign nib_sh = {cnt_q, 2'b00};
  assign a_nib  = 4'(a_q >> nib_sh);
  assign b_nib  = 4'(b_q >> nib_sh);

  bcd_digit u_digit (
    .sub_i   (op_q == OP_SBC),
    .a_i     (a_nib),
    .b_i     (b_nib),
    .c_i     (carry_q),
    .digit_o (dig),
    .c_o     (dig_c)
  );

  always_comb begin
    bcd_res         = (result_q & ~(NIB_MASK << nib_sh)) | (WIDTH'(dig) << nib_sh);
    bcd_st          = stin_q;
    bcd_st[FLAG_C]  = dig_c;
    bcd_st[FLAG_V]  = bin_v;
    bcd_st[FLAG_Z]  = ~|bcd_res;
    bcd_st[FLAG_N]  = bcd_res[WIDTH-1];
  end

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    stin_d   = stin_q;
    result_d = result_q;
    status_d = status_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d    = op;
          a_d     = a;
          b_d     = b;
          stin_d  = status_in;
          cnt_d   = '0;
          carry_d = (op == OP_ADD) ? 1'b0 : status_in[FLAG_C];
          state_d = (status_in[FLAG_D] && is_arith(op)) ? ST_BCD : ST_EXEC;
        end
      end
      ST_EXEC: begin
        result_d = exec_res;
        status_d = exec_st;
        state_d  = ST_DONE;
      end
      ST_BCD: begin
        result_d = bcd_res;
        carry_d  = dig_c;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(NDIG - 1)) begin
          status_d = bcd_st;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      stin_q   <= '0;
      result_q <= '0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      stin_q   <= stin_d;
      result_q <= result_d;
      status_q <= status_d;
    end
  end

  assign in_ready   = (state_q == ST_IDLE) && !rst;
  assign out_valid  = (state_q == ST_DONE);
  assign result     = result_q;
  assign status_out = status_q;

endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core at WIDTH=8 and WIDTH=16 against an arithmetic model.
// Latency: n/a.
// Backpressure: exercised by holding out_ready low in DONE.
module tb_alu_core;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, out_ready, sel;
  logic [3:0]  op;
  logic [15:0] a, b;
  logic [7:0]  st;

  logic        rdy8, vld8, rdy16, vld16;
  logic [7:0]  res8, so8, so16;
  logic [15:0] res16;

  alu_core #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid & ~sel), .in_ready(rdy8), .op(op),
    .a(a[7:0]), .b(b[7:0]), .status_in(st), .out_valid(vld8),
    .out_ready(out_ready & ~sel), .result(res8), .status_out(so8)
  );

  alu_core #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid & sel), .in_ready(rdy16), .op(op),
    .a(a), .b(b), .status_in(st), .out_valid(vld16),
    .out_ready(out_ready & sel), .result(res16), .status_out(so16)
  );

  wire        rdy_x = sel ? rdy16 : rdy8;
  wire        vld_x = sel ? vld16 : vld8;
  wire [15:0] res_x = sel ? res16 : {8'h00, res8};
  wire [7:0]  so_x  = sel ? so16 : so8;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: each op evaluated with plain integer arithmetic on the spec rules.
  function automatic void model(input int w, input logic [3:0] o, input logic [15:0] av,
                                input logic [15:0] bv, input logic [7:0] sv,
                                output logic [15:0] r, output logic [7:0] so, output int lat);
    int m, half, ai, bi, c, sa, sb, s, sum, res, carry, an, bn, d;
    bit zn, dec;
    m    = (1 << w) - 1;
    half = 1 << (w - 1);
    ai   = int'(av);
    bi   = int'(bv);
    c    = sv[7] ? 1 : 0;
    sa   = (ai >= half) ? ai - 2 * half : ai;
    sb   = (bi >= half) ? bi - 2 * half : bi;
    so   = sv;
    res  = ai;
    zn   = 1'b1;
    lat  = 1;
    dec  = sv[4] && (o <= 4'd2);
    case (o)
      4'd0, 4'd1: begin
        s     = (o == 4'd1) ? c : 0;
        sum   = ai + bi + s;
        res   = sum & m;
        so[7] = (sum > m);
        s     = sa + sb + s;
        so[1] = (s < -half) || (s >= half);
      end
      4'd2: begin
        sum   = ai + (m - bi) + c;
        res   = sum & m;
        so[7] = (sum > m);
        s     = sa - sb - (1 - c);
        so[1] = (s < -half) || (s >= half);
      end
      4'd3: res = ai & bi;
      4'd4: res = ai ^ bi;
      4'd5: res = ai | bi;
      4'd6: begin
        res   = ai;
        so[6] = ((ai & bi) == 0);
        so[0] = (bi >= half);
        so[1] = (((bi >> (w - 2)) & 1) != 0);
        zn    = 1'b0;
      end
      4'd7:  begin res = (bi * 2) & m;     so[7] = (bi >= half); end
      4'd8:  begin res = bi / 2;           so[7] = (bi % 2 == 1); end
      4'd9:  begin res = (bi * 2 + c) & m; so[7] = (bi >= half); end
      4'd10: begin res = bi / 2 + c * half; so[7] = (bi % 2 == 1); end
      4'd11: res = bi;
      default: zn = 1'b0;
    endcase
    if (dec) begin
      carry = (o == 4'd0) ? 0 : c;
      res   = 0;
      for (int i = 0; i < w / 4; i++) begin
        an = (ai >> (4 * i)) & 15;
        bn = (bi >> (4 * i)) & 15;
        if (o == 4'd2) begin
          s = an - bn - (1 - carry);
          if (s < 0) begin d = (s - 6) & 15; carry = 0; end
          else       begin d = s;            carry = 1; end
        end else begin
          s = an + bn + carry;
          if (s > 9) begin d = (s + 6) & 15; carry = 1; end
          else       begin d = s;            carry = 0; end
        end
        res = res + (d << (4 * i));
      end
      so[7] = (carry == 1);
      lat   = w / 4;
    end
    if (zn) begin
      so[6] = (res == 0);
      so[0] = (res >= half);
    end
    r = 16'(res);
  endfunction

  task automatic run_op(input bit s, input logic [3:0] o, input logic [15:0] av,
                        input logic [15:0] bv, input logic [7:0] sv, input int hold,
                        output logic [15:0] ro, output logic [7:0] so_o);
    logic [15:0] er;
    logic [7:0]  es;
    int          exp_lat, lat;
    model(s ? 16 : 8, o, av, bv, sv, er, es, exp_lat);
    @(negedge clk);
    sel = s; op = o; a = av; b = bv; st = sv; in_valid = 1'b1; out_ready = 1'b0;
    #1;
    check("rdy_before_accept", 32'(rdy_x), 1);
    @(posedge clk); #1;
    // Scramble inputs so anything leaking from the live ports shows up.
    in_valid = 1'b0;
    op = 4'($urandom); a = 16'($urandom); b = 16'($urandom); st = 8'($urandom);
    lat = 0;
    while (!vld_x && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("result", 32'(res_x), 32'(er));
    check("status", 32'(so_x), 32'(es));
    ro   = res_x;
    so_o = so_x;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_result", 32'(res_x), 32'(er));
      check("hold_status", 32'(so_x), 32'(es));
      check("hold_in_ready", 32'(rdy_x), 0);
      check("hold_out_valid", 32'(vld_x), 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release_out_valid", 32'(vld_x), 0);
    check("release_in_ready", 32'(rdy_x), 1);
  endtask

  logic [15:0] r;
  logic [7:0]  s;
  bit          seen;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sel = 1'b0;
    op = '0; a = '0; b = '0; st = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready8", 32'(rdy8), 0);
    check("rst_in_ready16", 32'(rdy16), 0);
    check("rst_out_valid8", 32'(vld8), 0);
    check("rst_result8", 32'(res8), 0);
    check("rst_status8", 32'(so8), 0);
    check("rst_result16", 32'(res16), 0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready8", 32'(rdy8), 1);

    // Directed vectors.
    run_op(1'b0, 4'd1, 16'h50, 16'h50, 8'h00, 0, r, s);
    check("adc_bin_res", 32'(r), 32'hA0);
    check("adc_bin_V", 32'(s[1]), 1);
    check("adc_bin_N", 32'(s[0]), 1);
    check("adc_bin_C", 32'(s[7]), 0);
    check("adc_bin_Z", 32'(s[6]), 0);

    run_op(1'b0, 4'd1, 16'h99, 16'h01, 8'h10, 0, r, s);
    check("adc_dec_res", 32'(r), 32'h00);
    check("adc_dec_C", 32'(s[7]), 1);
    check("adc_dec_Z", 32'(s[6]), 1);

    run_op(1'b0, 4'd2, 16'h42, 16'h13, 8'h90, 0, r, s);
    check("sbc_dec_res", 32'(r), 32'h29);
    check("sbc_dec_C", 32'(s[7]), 1);

    run_op(1'b0, 4'd2, 16'h00, 16'h01, 8'h80, 0, r, s);
    check("sbc_bin_res", 32'(r), 32'hFF);
    check("sbc_bin_C", 32'(s[7]), 0);
    check("sbc_bin_N", 32'(s[0]), 1);

    run_op(1'b0, 4'd10, 16'h33, 16'h01, 8'h80, 0, r, s);
    check("ror_res", 32'(r), 32'h80);
    check("ror_C", 32'(s[7]), 1);
    check("ror_N", 32'(s[0]), 1);

    run_op(1'b0, 4'd6, 16'h0F, 16'hC0, 8'h00, 0, r, s);
    check("bit_res", 32'(r), 32'h0F);
    check("bit_Z", 32'(s[6]), 1);
    check("bit_N", 32'(s[0]), 1);
    check("bit_V", 32'(s[1]), 1);

    // Backpressure: DONE held 3 cycles, then back-to-back accept.
    run_op(1'b0, 4'd0, 16'h7F, 16'h01, 8'h24, 3, r, s);
    run_op(1'b0, 4'd5, 16'h0A, 16'hA0, 8'h00, 0, r, s);

    // Randomized, both widths.
    for (int i = 0; i < 150; i++)
      run_op(1'b0, 4'($urandom), 16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)),
             8'($urandom), $urandom_range(0, 2), r, s);
    for (int i = 0; i < 40; i++)
      run_op(1'b1, 4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom),
             8'($urandom), $urandom_range(0, 1), r, s);

    // Reset during the 2nd decimal cycle at WIDTH=16 aborts the operation.
    @(negedge clk);
    sel = 1'b1; op = 4'd1; a = 16'h1234; b = 16'h5678; st = 8'h10; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("mid_bcd_out_valid", 32'(vld16), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("abort_result16", 32'(res16), 0);
    check("abort_in_ready16", 32'(rdy16), 1);
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (vld16) seen = 1'b1;
    end
    check("abort_no_out_valid", 32'(seen), 0);
    run_op(1'b1, 4'd1, 16'h0999, 16'h0001, 8'h10, 0, r, s);
    check("after_abort_res16", 32'(r), 32'h1000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_core.md
ALU_CORE -- requirements
Module: alu_core

Interface
REQ-001 SHALL have parameter WIDTH, default 8, datapath width; a multiple of 4 and at least 8.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  the operation request is valid.
REQ-005 SHALL have port in_ready  output  1  the block can accept an operation.
REQ-006 SHALL have port op  input  4  operation code.
REQ-007 SHALL have port a  input  WIDTH  accumulator operand.
REQ-008 SHALL have port b  input  WIDTH  second operand, which is also the shift source.
REQ-009 SHALL have port status_in  input  8  flags; C=7, Z=6, I=5, D=4, B=3, bit 2 unused, V=1, N=0.
REQ-010 SHALL have port out_valid  output  1  result and status_out are valid.
REQ-011 SHALL have port out_ready  input  1  the consumer accepts the result.
REQ-012 SHALL have port result  output  WIDTH  the operation result.
REQ-013 SHALL have port status_out  output  8  the updated flags.

Function
REQ-014 Op codes SHALL be: ADD=0, ADC=1, SBC=2, AND=3, EOR=4, ORA=5, BIT=6, ASL=7, LSR=8, ROL=9, ROR=10, PASS=11; codes 12-15 are reserved.
REQ-015 The FSM SHALL have four states: IDLE (in_ready=1), EXEC, BCD, DONE (out_valid=1).
REQ-016 The block SHALL accept a request when in_valid and in_ready are both high at a clock edge, registering op, a, b and status_in.
REQ-017 Transitions from IDLE on accept SHALL be: EXEC, or BCD if status_in[4]=1 and op is ADD, ADC or SBC.
REQ-018 EXEC SHALL take one cycle, then go to DONE; binary latency from accept to out_valid is 1 cycle.
REQ-019 BCD SHALL process one nibble per cycle, LSB first, for WIDTH/4 cycles, then go to DONE; decimal latency is WIDTH/4 cycles.
REQ-020 DONE SHALL hold result and status_out stable until out_ready=1, then return to IDLE; there is no accept in the same cycle.
REQ-021 Binary ADD/ADC SHALL compute a+b+cin, with cin=0 for ADD and cin=C for ADC; C = carry out of MSB; V = signed overflow.
REQ-022 Binary SBC SHALL compute a+~b+C; C=1 means no borrow; V = signed overflow.
REQ-023 Each BCD add nibble SHALL compute s=a_n+b_n+c; if s>9 then digit=(s+6) mod 16 and c=1, else digit=s and c=0.
REQ-024 Each BCD SBC nibble SHALL compute s=a_n-b_n-(1-c); if s<0 then digit=(s-6) mod 16 and c=0, else digit=s and c=1.
REQ-025 BCD SHALL NOT range-check nibbles greater than 9; the rule in REQ-023 or REQ-024 applies as written.
REQ-026 In BCD, C SHALL be the final digit carry, and V SHALL be the binary-mode V for the same operands.
REQ-027 AND, EOR and ORA SHALL set result to a op b; C and V unchanged.
REQ-028 BIT SHALL set result=a; Z=((a&b)==0); N=b[WIDTH-1]; V=b[WIDTH-2]; C unchanged.
REQ-029 ASL and LSR SHALL shift b, with 0 shifted in; C = the bit shifted out.
REQ-030 ROL and ROR SHALL shift b, with C shifted in; C = the bit shifted out.
REQ-031 PASS SHALL set result=b with Z and N updated; reserved codes SHALL set result=a with status_out=status_in.
REQ-032 Except where stated, Z SHALL be (result==0) and N SHALL be result[WIDTH-1].
REQ-033 Bits I, D, B and 2 SHALL always copy the captured status_in.
REQ-034 Input changes after accept SHALL NOT affect the operation in flight.

Reset
REQ-035 With rst high at an edge, the block SHALL enter IDLE with result=0, status_out=0, out_valid=0 and the nibble counter at 0.
REQ-036 in_ready SHALL be 0 while rst is high and 1 in the first cycle after rst falls.
REQ-037 A reset mid-BCD or in DONE SHALL abort the operation; no out_valid follows.

Structure
REQ-038 A shared package alu_pkg SHALL hold the op-code constants, flag bit indices and FSM state encodings.
REQ-039 A single combinational sub-module bcd_digit SHALL perform one nibble add/subtract with carry in and carry out; it is instantiated once and reused each BCD cycle.

Verification
REQ-040 ADC, D=0, C=0, a=0x50, b=0x50 SHALL give result=0xA0, V=1, N=1, C=0, Z=0, with out_valid 1 cycle after accept.
REQ-041 ADC, D=1, C=0, a=0x99, b=0x01 SHALL give result=0x00, C=1, Z=1, with out_valid 2 cycles after accept (WIDTH=8).
REQ-042 SBC, D=1, C=1, a=0x42, b=0x13 SHALL give result=0x29 and C=1; SBC, D=0, C=1, a=0x00, b=0x01 SHALL give result=0xFF, C=0, N=1.
REQ-043 ROR with b=0x01, C=1 SHALL give result=0x80, C=1, N=1; BIT with a=0x0F, b=0xC0 SHALL give result=0x0F, Z=1, N=1, V=1.
REQ-044 Holding out_ready=0 for 3 cycles in DONE SHALL keep result stable and in_ready=0; on out_ready=1, the next request SHALL be accepted the following cycle.
REQ-045 With WIDTH=16, a decimal ADC with rst pulsed during the 2nd BCD cycle SHALL produce no out_valid, and result=0 and in_ready=1 the cycle after rst falls.
